// File: rtl/qdma_sequencer_if.sv
// Bus-side signals between the DMA sequencer (master) and the QBUS master state machine (slave).
interface qdma_sequencer_if;
    logic        dma_read;
    logic        dma_write;
    logic        bus_master;
    logic        dma_complete;
    logic        nxm;
    logic [21:0] bus_addr;
    logic [15:0] bus_wdata;
    logic [15:0] bus_rdata;

    modport master (
        output dma_read, dma_write, bus_addr, bus_wdata,
        input  bus_master, dma_complete, nxm, bus_rdata
    );

    modport slave (
        input  dma_read, dma_write, bus_addr, bus_wdata,
        output bus_master, dma_complete, nxm, bus_rdata
    );
endinterface

// File: rtl/qdma_sequencer.sv
// Word-level DMA sequencer: one single-word QBUS request per bus tenure, with
// write/read data FIFOs decoupling the device side from bus timing.
module qdma_sequencer #(
    parameter int FIFO_AW = 2
) (
    input  logic                   clk,
    input  logic                   nreset,
    input  logic                   bus_init,
    // Command handshake: accepted on a cycle where cmd_valid and cmd_ready are both high.
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic                   cmd_write,
    input  logic [21:0]            cmd_addr,
    input  logic [15:0]            cmd_count,
    input  logic                   abort,
    input  logic [15:0]            wdata,
    input  logic                   wdata_valid,
    output logic                   wdata_ready,
    output logic [15:0]            rdata,
    output logic                   rdata_valid,
    input  logic                   rdata_ready,
    qdma_sequencer_if.master       bus,
    output logic                   busy,
    output logic                   done,
    output logic                   error,
    output logic [15:0]            words_left,
    output logic [1:0]             state_dbg
);
    localparam int DEPTH = 1 << FIFO_AW;

    typedef enum logic [1:0] {S_IDLE, S_ARM, S_XFER, S_RELEASE} state_t;

    state_t      state_q, state_d;
    logic        write_q, write_d;
    logic [21:0] addr_q, addr_d;
    logic [15:0] left_q, left_d;
    logic        error_q, error_d;
    logic        done_q, done_d;
    logic        rd_req_q, rd_req_d;
    logic        wr_req_q, wr_req_d;
    logic        nxm_seen_q, nxm_seen_d;
    logic        abort_seen_q, abort_seen_d;

    logic [15:0]      wmem_q [DEPTH];
    logic [15:0]      rmem_q [DEPTH];
    logic [FIFO_AW:0] w_wr_q, w_wr_d, w_rd_q, w_rd_d;
    logic [FIFO_AW:0] r_wr_q, r_wr_d, r_rd_q, r_rd_d;
    logic             w_push, w_pop, w_flush, w_full, w_empty;
    logic             r_push, r_pop, r_flush, r_full, r_empty;

    assign w_empty = (w_wr_q == w_rd_q);
    assign w_full  = (w_wr_q[FIFO_AW] != w_rd_q[FIFO_AW]) &&
                     (w_wr_q[FIFO_AW-1:0] == w_rd_q[FIFO_AW-1:0]);
    assign r_empty = (r_wr_q == r_rd_q);
    assign r_full  = (r_wr_q[FIFO_AW] != r_rd_q[FIFO_AW]) &&
                     (r_wr_q[FIFO_AW-1:0] == r_rd_q[FIFO_AW-1:0]);
    assign w_push  = wdata_valid && !w_full && !w_flush;
    assign r_pop   = rdata_ready && !r_empty && !r_flush;

    always_comb begin
        state_d      = state_q;
        write_d      = write_q;
        addr_d       = addr_q;
        left_d       = left_q;
        error_d      = error_q;
        done_d       = 1'b0;
        rd_req_d     = rd_req_q;
        wr_req_d     = wr_req_q;
        nxm_seen_d   = nxm_seen_q;
        abort_seen_d = abort_seen_q;
        w_pop        = 1'b0;
        w_flush      = 1'b0;
        r_push       = 1'b0;
        r_flush      = 1'b0;
        if (bus_init) begin
            rd_req_d     = 1'b0;
            wr_req_d     = 1'b0;
            nxm_seen_d   = 1'b0;
            abort_seen_d = 1'b0;
            w_flush      = 1'b1;
            r_flush      = 1'b1;
            state_d      = S_IDLE;
            if (state_q != S_IDLE) begin
                error_d = 1'b1;
                done_d  = 1'b1;
            end
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (cmd_valid) begin
                        write_d      = cmd_write;
                        addr_d       = {cmd_addr[21:1], 1'b0};
                        left_d       = cmd_count;
                        error_d      = 1'b0;
                        nxm_seen_d   = 1'b0;
                        abort_seen_d = 1'b0;
                        if (cmd_count == 16'd0) done_d  = 1'b1;
                        else                    state_d = S_ARM;
                    end
                end
                S_ARM: begin
                    if (abort) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                        w_flush = 1'b1;
                    end else if (!bus.bus_master) begin
                        // A read only starts with a free slot, so the capture can never overflow.
                        if (write_q && !w_empty) begin
                            wr_req_d = 1'b1;
                            state_d  = S_XFER;
                        end else if (!write_q && !r_full) begin
                            rd_req_d = 1'b1;
                            state_d  = S_XFER;
                        end
                    end
                end
                S_XFER: begin
                    if (abort) abort_seen_d = 1'b1;
                    if (bus.nxm) begin
                        rd_req_d   = 1'b0;
                        wr_req_d   = 1'b0;
                        error_d    = 1'b1;
                        nxm_seen_d = 1'b1;
                        state_d    = S_RELEASE;
                    end else if (bus.dma_complete && !nxm_seen_q) begin
                        // Master has already latched address and data, so advancing now is safe.
                        rd_req_d = 1'b0;
                        wr_req_d = 1'b0;
                        w_pop    = write_q;
                        r_push   = !write_q;
                        addr_d   = addr_q + 22'd2;
                        left_d   = left_q - 16'd1;
                        state_d  = S_RELEASE;
                    end
                end
                S_RELEASE: begin
                    if (abort) abort_seen_d = 1'b1;
                    if (!bus.bus_master) begin
                        nxm_seen_d = 1'b0;
                        if (error_q || abort_seen_q || abort) begin
                            state_d = S_IDLE;
                            done_d  = 1'b1;
                            w_flush = 1'b1;
                        end else if (left_q == 16'd0) begin
                            state_d = S_IDLE;
                            done_d  = 1'b1;
                        end else begin
                            state_d = S_ARM;
                        end
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        w_wr_d = w_wr_q + (FIFO_AW+1)'(w_push);
        w_rd_d = w_rd_q + (FIFO_AW+1)'(w_pop);
        r_wr_d = r_wr_q + (FIFO_AW+1)'(r_push);
        r_rd_d = r_rd_q + (FIFO_AW+1)'(r_pop);
        if (w_flush) begin
            w_wr_d = '0;
            w_rd_d = '0;
        end
        if (r_flush) begin
            r_wr_d = '0;
            r_rd_d = '0;
        end
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_q      <= S_IDLE;
            write_q      <= 1'b0;
            addr_q       <= '0;
            left_q       <= '0;
            error_q      <= 1'b0;
            done_q       <= 1'b0;
            rd_req_q     <= 1'b0;
            wr_req_q     <= 1'b0;
            nxm_seen_q   <= 1'b0;
            abort_seen_q <= 1'b0;
            w_wr_q       <= '0;
            w_rd_q       <= '0;
            r_wr_q       <= '0;
            r_rd_q       <= '0;
        end else begin
            state_q      <= state_d;
            write_q      <= write_d;
            addr_q       <= addr_d;
            left_q       <= left_d;
            error_q      <= error_d;
            done_q       <= done_d;
            rd_req_q     <= rd_req_d;
            wr_req_q     <= wr_req_d;
            nxm_seen_q   <= nxm_seen_d;
            abort_seen_q <= abort_seen_d;
            w_wr_q       <= w_wr_d;
            w_rd_q       <= w_rd_d;
            r_wr_q       <= r_wr_d;
            r_rd_q       <= r_rd_d;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) wmem_q[w_wr_q[FIFO_AW-1:0]] <= wdata;
        if (r_push) rmem_q[r_wr_q[FIFO_AW-1:0]] <= bus.bus_rdata;
    end

    assign bus.dma_read  = rd_req_q;
    assign bus.dma_write = wr_req_q;
    assign bus.bus_addr  = addr_q;
    assign bus.bus_wdata = wmem_q[w_rd_q[FIFO_AW-1:0]];
    assign rdata         = rmem_q[r_rd_q[FIFO_AW-1:0]];
    assign rdata_valid   = !r_empty;
    assign wdata_ready   = !w_full;
    assign cmd_ready     = (state_q == S_IDLE);
    assign busy          = (state_q != S_IDLE);
    assign done          = done_q;
    assign error         = error_q;
    assign words_left    = left_q;
    assign state_dbg     = state_q;
endmodule

// File: tb/tb_qdma_sequencer.sv
// Self-checking bench for qdma_sequencer: table of transfers plus directed corner sequences.
module tb_qdma_sequencer;
    logic        clk = 1'b0;
    logic        nreset, bus_init;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [21:0] cmd_addr;
    logic [15:0] cmd_count;
    logic        abort;
    logic [15:0] wdata;
    logic        wdata_valid, wdata_ready;
    logic [15:0] rdata;
    logic        rdata_valid, rdata_ready;
    logic        busy, done, error;
    logic [15:0] words_left;
    logic [1:0]  state_dbg;
    logic        req;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [15:0] exp_q[$];

    qdma_sequencer_if bus_if();

    qdma_sequencer #(.FIFO_AW(2)) dut (
        .clk(clk), .nreset(nreset), .bus_init(bus_init),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_count(cmd_count), .abort(abort),
        .wdata(wdata), .wdata_valid(wdata_valid), .wdata_ready(wdata_ready),
        .rdata(rdata), .rdata_valid(rdata_valid), .rdata_ready(rdata_ready),
        .bus(bus_if), .busy(busy), .done(done), .error(error),
        .words_left(words_left), .state_dbg(state_dbg)
    );

    // Clock and watchdog
    always #25 clk = ~clk;
    assign req = bus_if.dma_read | bus_if.dma_write;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    typedef struct packed {
        logic             wr;
        logic [21:0]      addr;
        logic [15:0]      count;
        logic [3:0][15:0] data;
        logic [3:0][21:0] exp_addr;
        logic [21:0]      exp_end;
    } vec_t;

    vec_t vecs[5];

    function automatic vec_t mk(logic wr, logic [21:0] addr, logic [15:0] count,
                                logic [15:0] d0, logic [15:0] d1, logic [15:0] d2, logic [15:0] d3,
                                logic [21:0] a0, logic [21:0] a1, logic [21:0] a2, logic [21:0] a3,
                                logic [21:0] aend);
        vec_t v;
        v.wr = wr; v.addr = addr; v.count = count;
        v.data[0] = d0; v.data[1] = d1; v.data[2] = d2; v.data[3] = d3;
        v.exp_addr[0] = a0; v.exp_addr[1] = a1; v.exp_addr[2] = a2; v.exp_addr[3] = a3;
        v.exp_end = aend;
        return v;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Driver tasks
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic push_w(input logic [15:0] d);
        wdata = d;
        wdata_valid = 1'b1;
        tick();
        wdata_valid = 1'b0;
    endtask

    task automatic send_cmd(input logic wr, input logic [21:0] addr, input logic [15:0] count);
        check("cmd_ready", cmd_ready, 1);
        cmd_write = wr;
        cmd_addr  = addr;
        cmd_count = count;
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        check("error_clr_on_accept", error, 0);
    endtask

    task automatic wait_req(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (req) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        check("req_wait", ok, 1);
    endtask

    // Models one bus tenure ending in a normal dma_complete.
    task automatic do_tenure(input logic exp_wr, input logic [21:0] exp_addr, input logic [15:0] d);
        bit ok;
        wait_req(ok);
        if (!ok) return;
        check("req_dir_write", bus_if.dma_write, exp_wr);
        check("req_dir_read", bus_if.dma_read, !exp_wr);
        check("bus_addr", bus_if.bus_addr, exp_addr);
        if (exp_wr) check("bus_wdata", bus_if.bus_wdata, d);
        bus_if.bus_master = 1'b1;
        tick();
        tick();
        check("req_hold", req, 1);
        bus_if.dma_complete = 1'b1;
        bus_if.bus_rdata    = d;
        tick();
        bus_if.dma_complete = 1'b0;
        check("req_drop", req, 0);
        if (!exp_wr) exp_q.push_back(d);
        tick();
        bus_if.bus_master = 1'b0;
        tick();
        check("one_word_per_tenure", req, 0);
    endtask

    task automatic pop_read(input int n);
        logic [15:0] e;
        for (int i = 0; i < n; i++) begin
            check("rdata_valid", rdata_valid, 1);
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hxxxx;
            check("rdata", rdata, e);
            rdata_ready = 1'b1;
            tick();
            rdata_ready = 1'b0;
        end
    endtask

    initial begin
        bit ok;
        int held;

        vecs[0] = mk(1'b0, 22'h001000, 16'd3, 16'hA001, 16'hA002, 16'hA003, 16'h0000,
                     22'h001000, 22'h001002, 22'h001004, 22'h0, 22'h001006);
        vecs[1] = mk(1'b1, 22'h3FFFFE, 16'd2, 16'h1111, 16'h2222, 16'h0000, 16'h0000,
                     22'h3FFFFE, 22'h000000, 22'h0, 22'h0, 22'h000002);
        vecs[2] = mk(1'b0, 22'h000011, 16'd1, 16'hBEEF, 16'h0000, 16'h0000, 16'h0000,
                     22'h000010, 22'h0, 22'h0, 22'h0, 22'h000012);
        vecs[3] = mk(1'b1, 22'h0ABCDE, 16'd4, 16'h4001, 16'h4002, 16'h4003, 16'h4004,
                     22'h0ABCDE, 22'h0ABCE0, 22'h0ABCE2, 22'h0ABCE4, 22'h0ABCE6);
        vecs[4] = mk(1'b0, 22'h000500, 16'd0, 16'h0000, 16'h0000, 16'h0000, 16'h0000,
                     22'h0, 22'h0, 22'h0, 22'h0, 22'h000500);

        // Reset block
        nreset = 1'b0; bus_init = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0;
        cmd_addr = '0; cmd_count = '0; abort = 1'b0; wdata = '0; wdata_valid = 1'b0;
        rdata_ready = 1'b0;
        bus_if.bus_master = 1'b0; bus_if.dma_complete = 1'b0; bus_if.nxm = 1'b0;
        bus_if.bus_rdata = '0;
        repeat (3) tick();
        nreset = 1'b1;
        tick();
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_error", error, 0);
        check("rst_req", req, 0);
        check("rst_bus_addr", bus_if.bus_addr, 0);
        check("rst_words_left", words_left, 0);
        check("rst_wdata_ready", wdata_ready, 1);
        check("rst_rdata_valid", rdata_valid, 0);

        // Table-driven transfers
        for (int v = 0; v < 5; v++) begin
            if (vecs[v].wr) begin
                for (int k = 0; k < int'(vecs[v].count); k++) push_w(vecs[v].data[k]);
                check("wdata_ready_preload", wdata_ready, (vecs[v].count < 16'd4) ? 1 : 0);
            end
            send_cmd(vecs[v].wr, vecs[v].addr, vecs[v].count);
            if (vecs[v].count == 16'd0) begin
                check("null_done", done, 1);
                check("null_busy", busy, 0);
                check("null_req", req, 0);
            end else begin
                check("arm_no_req", req, 0);
                check("arm_busy", busy, 1);
                tick();
                check("req_latency", req, 1);
                for (int k = 0; k < int'(vecs[v].count); k++)
                    do_tenure(vecs[v].wr, vecs[v].exp_addr[k], vecs[v].data[k]);
                check("done", done, 1);
                check("idle_after", busy, 0);
            end
            check("error_clean", error, 0);
            check("words_left_end", words_left, 0);
            check("bus_addr_end", bus_if.bus_addr, vecs[v].exp_end);
            tick();
            check("done_one_cycle", done, 0);
            if (!vecs[v].wr) pop_read(int'(vecs[v].count));
            check("rdata_drained", rdata_valid, 0);
            check("wdata_ready_end", wdata_ready, 1);
        end

        // Write NXM on word 2 of 4
        for (int k = 0; k < 4; k++) push_w(16'h3001 + 16'(k));
        send_cmd(1'b1, 22'h000100, 16'd4);
        do_tenure(1'b1, 22'h000100, 16'h3001);
        wait_req(ok);
        check("nxm_w_addr", bus_if.bus_addr, 22'h000102);
        check("nxm_w_wdata", bus_if.bus_wdata, 16'h3002);
        bus_if.bus_master = 1'b1;
        tick();
        bus_if.nxm = 1'b1;
        tick();
        bus_if.nxm = 1'b0;
        check("nxm_w_req_drop", req, 0);
        check("nxm_w_error", error, 1);
        check("nxm_w_words_left", words_left, 3);
        tick();
        check("nxm_w_wait_release", done, 0);
        check("nxm_w_busy", busy, 1);
        bus_if.bus_master = 1'b0;
        tick();
        check("nxm_w_done", done, 1);
        check("nxm_w_idle", busy, 0);
        tick();
        push_w(16'h3AAA);
        check("nxm_w_flushed", wdata_ready, 1);
        send_cmd(1'b1, 22'h000600, 16'd1);
        do_tenure(1'b1, 22'h000600, 16'h3AAA);
        check("after_flush_done", done, 1);
        tick();

        // Read NXM followed by a late dma_complete
        send_cmd(1'b0, 22'h000200, 16'd2);
        wait_req(ok);
        bus_if.bus_master = 1'b1;
        tick();
        bus_if.nxm = 1'b1;
        tick();
        bus_if.nxm = 1'b0;
        check("nxm_r_req_drop", req, 0);
        bus_if.dma_complete = 1'b1;
        bus_if.bus_rdata = 16'hDEAD;
        tick();
        bus_if.dma_complete = 1'b0;
        check("nxm_r_no_push", rdata_valid, 0);
        check("nxm_r_words_left", words_left, 2);
        check("nxm_r_error", error, 1);
        bus_if.bus_master = 1'b0;
        tick();
        check("nxm_r_done", done, 1);
        tick();

        // Read-FIFO back-pressure: 6 words, consumer stalled
        send_cmd(1'b0, 22'h000300, 16'd6);
        for (int k = 0; k < 4; k++) do_tenure(1'b0, 22'h000300 + 22'(2 * k), 16'hC001 + 16'(k));
        held = 0;
        for (int i = 0; i < 10; i++) begin
            if (req) held++;
            tick();
        end
        check("bp_no_request", held, 0);
        check("bp_busy", busy, 1);
        check("bp_words_left", words_left, 2);
        pop_read(4);
        for (int k = 4; k < 6; k++) do_tenure(1'b0, 22'h000300 + 22'(2 * k), 16'hC001 + 16'(k));
        check("bp_done", done, 1);
        tick();
        pop_read(2);
        check("bp_drained", rdata_valid, 0);

        // bus_init in the middle of a read tenure
        send_cmd(1'b0, 22'h000400, 16'd2);
        wait_req(ok);
        bus_if.bus_master = 1'b1;
        tick();
        bus_init = 1'b1;
        tick();
        bus_init = 1'b0;
        check("init_req_drop", req, 0);
        check("init_idle", busy, 0);
        check("init_error", error, 1);
        check("init_done", done, 1);
        bus_if.bus_master = 1'b0;
        tick();
        check("init_done_one_cycle", done, 0);
        check("init_rfifo_empty", rdata_valid, 0);

        // Abort while waiting in ARM for write data
        send_cmd(1'b1, 22'h000700, 16'd1);
        tick();
        check("abort_arm_wait", req, 0);
        check("abort_arm_busy", busy, 1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_done", done, 1);
        check("abort_idle", busy, 0);
        check("abort_error", error, 0);
        tick();

        // Asynchronous reset mid-transfer
        push_w(16'h5555);
        send_cmd(1'b1, 22'h000800, 16'd1);
        wait_req(ok);
        nreset = 1'b0;
        #1;
        check("arst_req", req, 0);
        check("arst_busy", busy, 0);
        check("arst_cmd_ready", cmd_ready, 1);
        check("arst_bus_addr", bus_if.bus_addr, 0);
        check("arst_words_left", words_left, 0);
        check("arst_error", error, 0);
        check("arst_done", done, 0);
        check("arst_wdata_ready", wdata_ready, 1);
        check("arst_rdata_valid", rdata_valid, 0);
        tick();
        nreset = 1'b1;
        tick();

        // Final report
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/qdma_sequencer.md
# qdma_sequencer

Word-level DMA sequencer that sits directly upstream of the QBUS master state machine. It accepts a transfer command (start address, word count, direction) from the device logic and issues one single-word DMA request per bus tenure on `dma_read`/`dma_write`. It supplies the address and write data, and captures read data on `dma_complete`. Two small FIFOs decouple the device-side data streams from bus timing, and the block reports completion, NXM errors and aborts.

## Interface
- `FIFO_AW`, default 2: log2 depth of each data FIFO (default 4 words).
- `clk`  in  1  20 MHz system clock, same clock as the QBUS master.
- `nreset`  in  1  reset, asynchronous, active-low.
- `bus_init`  in  1  synchronized RINIT; synchronous abort of everything.
- `cmd_valid`  in  1  command offered.
- `cmd_ready`  out  1  high only in IDLE.
- `cmd_write`  in  1  1 = device→memory (`dma_write`), 0 = memory→device (`dma_read`).
- `cmd_addr`  in  22  byte address; bit 0 is ignored and forced to 0.
- `cmd_count`  in  16  word count; 0 = null command.
- `abort`  in  1  request early termination.
- `wdata`, `wdata_valid`, `wdata_ready`  in/in/out  16/1/1  write-data FIFO push.
- `rdata`, `rdata_valid`, `rdata_ready`  out/out/in  16/1/1  read-data FIFO pop; `rdata` is the FIFO head.
- `dma_read`, `dma_write`  out  1  registered requests to the bus master; never both high.
- `bus_master`  in  1  high while the bus master owns the bus.
- `dma_complete`  in  1  one-cycle pulse: word transferred or read data valid.
- `nxm`  in  1  one-cycle pulse: no reply within 10 µs.
- `bus_addr`  out  22  current word address.
- `bus_wdata`  out  16  write FIFO head.
- `bus_rdata`  in  16  data from the Am2908 receive path; valid on `dma_complete`.
- `busy`  out  1  state ≠ IDLE.
- `done`  out  1  one-cycle completion pulse.
- `error`  out  1  sticky NXM/init flag; cleared on command accept.
- `words_left`  out  16  remaining count.

## Operation
- **State IDLE**
  - On `cmd_valid`: latch direction, address (bit 0 = 0) and count; clear `error`.
  - count = 0: pulse `done` next cycle and stay in IDLE.
  - Otherwise go to ARM.
- **State ARM** (requires `bus_master` = 0)
  - Write: wait for the write FIFO to be non-empty.
  - Read: wait for the read FIFO to be not full. This reserves the slot, so the read FIFO cannot overflow.
  - When the condition holds, set `dma_write` or `dma_read` and go to XFER.
  - `abort` seen in ARM: go to IDLE, pulse `done`, `error` unchanged.
- **State XFER**
  - Hold the request, `bus_addr` and `bus_wdata` stable.
  - On `dma_complete` with no NXM latched for this word:
    - clear the request;
    - read: push `bus_rdata` into the read FIFO;
    - write: pop the write FIFO;
    - `bus_addr` += 2, wrapping 0x3FFFFE→0x000000;
    - `words_left` −= 1;
    - go to RELEASE.
  - Updating address and data on `dma_complete` is safe: the master has already latched both into the Am2908s.
  - On `nxm`: clear the request, set `error` and `nxm_seen`, go to RELEASE.
  - A read `dma_complete` following an NXM (one cycle later) is discarded: no push, no count change.
- **State RELEASE**
  - Wait for `bus_master` = 0, then clear `nxm_seen`.
  - If `error`, `abort` seen during this tenure, or `words_left` = 0: go to IDLE and pulse `done`.
  - Otherwise go to ARM. Exactly one word is transferred per tenure.
- **Error/abort exit:** flush the write FIFO. The read FIFO keeps data already captured.
- **Normal completion:** surplus write-FIFO words are retained for the next command.
- **`bus_init`** (any state): clear the request, flush both FIFOs, set `error` if `busy`, go to IDLE, pulse `done` if `busy`.
- **FIFOs**
  - `wdata_ready` = not full, independent of a same-cycle pop.
  - `rdata_valid` = not empty.
  - Simultaneous push and pop is legal whenever the respective full/empty rule allows.

## Timing
- **Reset** (`nreset` low): state IDLE; `dma_read`, `dma_write`, `done`, `error`, `busy` = 0; `cmd_ready` = 1; `bus_addr` = 0; `words_left` = 0; FIFOs empty; `wdata_ready` = 1; `rdata_valid` = 0.
- **Request latency:** command accepted in cycle 0 → ARM in cycle 1 → request high in cycle 2, provided the ARM condition holds.
- **Request drop:** `dma_complete` or `nxm` sampled in cycle n → request low in cycle n+1, before the master releases the bus.
- **Completion:** `bus_master` sampled low in cycle m → `done` high in cycle m+1 for exactly one cycle.
- **Next word:** with the FIFO ready, the next request rises at m+2 at the earliest.
- **Read data:** captured data appears on `rdata` one cycle after `dma_complete`.
- **Precedence:** `bus_init` > `nxm` > `dma_complete` > `abort`.

## Test plan
- **Read, 3 words:** read from 0x001000, with `bus_rdata` = 0xA001/0xA002/0xA003 on successive completions → addresses 0x001000/002/004, three separate request/release tenures, `rdata` yields the three words in order, `done` pulse, `error` = 0.
- **Write, 2 words:** write from 0x3FFFFE, FIFO preloaded 0x1111/0x2222 → `bus_wdata` 0x1111 at 0x3FFFFE, then 0x2222 at 0x000000 (wrap), `done` pulse, FIFO empty.
- **Write NXM:** write of 4 words, `nxm` on word 2 → request drops the next cycle, `error` = 1, `words_left` = 3, write FIFO flushed, `done` after `bus_master` falls.
- **Read NXM:** `nxm` then `dma_complete` one cycle later → no FIFO push, `error` = 1.
- **Read-FIFO back-pressure:** read of 6 words with `rdata_ready` = 0 → exactly 4 words captured, request held off in ARM; releasing `rdata_ready` resumes the transfer.
- **Init and reset:** null command → `done` in 1 cycle, no request. `bus_init` mid-XFER → request low the next cycle, IDLE, `error` = 1. `nreset` low → all outputs at their reset values immediately.
